// File: rtl/pairwise_match_arbiter.sv
// rtl/pairwise_match_arbiter.sv - two-requester round-robin front end for a shared 5-input XNOR-matrix unit
module pairwise_match_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             req0,
  input  logic [4:0]       vec0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [4:0]       vec1,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_match,
  output logic [4:0]       out_cnt,
  output logic             out_id,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [24:0]      out_match_q, out_match_d;
  logic [4:0]       out_cnt_q, out_cnt_d;
  logic             out_id_q, out_id_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             can_accept;
  logic             g0, g1;
  logic [4:0]       v_sel;
  logic [24:0]      m;
  logic [4:0]       pc;

  always_comb begin
    can_accept = !out_valid_q || out_ready;
    // ptr_q names the requester that wins a contended cycle
    g0 = areset_n && can_accept && req0 && (!req1 || !ptr_q);
    g1 = areset_n && can_accept && req1 && (!req0 || ptr_q);
    v_sel = g1 ? vec1 : vec0;

    m = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        m[24-(5*i+j)] = ~(v_sel[4-i] ^ v_sel[4-j]);
      end
    end
    pc = '0;
    for (int k = 0; k < 25; k++) begin
      pc = pc + 5'(m[k]);
    end

    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_match_d = out_match_q;
    out_cnt_d   = out_cnt_q;
    out_id_d    = out_id_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;

    if (g0) ptr_d = 1'b1;
    else if (g1) ptr_d = 1'b0;

    // A grant while draining reloads the slot on the same edge
    if (g0 || g1) begin
      out_valid_d = 1'b1;
      out_match_d = m;
      out_cnt_d   = pc;
      out_id_d    = g1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (g0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + CNT_W'(1);
    if (g1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ptr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_match_q <= '0;
      out_cnt_q   <= '0;
      out_id_q    <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_match_q <= out_match_d;
      out_cnt_q   <= out_cnt_d;
      out_id_q    <= out_id_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign gnt0      = g0;
  assign gnt1      = g1;
  assign out_valid = out_valid_q;
  assign out_match = out_match_q;
  assign out_cnt   = out_cnt_q;
  assign out_id    = out_id_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule
